// File: rtl/alu_mc_pkg.sv
// alu_mc_pkg: instruction/FSM types and the chunk decoder shared by alu_mc.
// DIV decodes as a legal op only when ALU_MC_DIV_EN is defined.
package alu_mc_pkg;

    typedef enum logic [2:0] {
        ADD, SUB, SHIFT_LEFT, SHIFT_RIGHT, MUL_LOW, MUL_HIGH, DIV, ILLEGAL
    } insn_t;

    typedef enum logic [1:0] {ST_IDLE, ST_MUL, ST_DIV, ST_DONE} state_t;

    localparam logic [6:0] F7_ARITH  = 7'b0000001;
    localparam logic [6:0] F7_SHIFT  = 7'b0000010;
    localparam logic [6:0] F7_MULDIV = 7'b0001000;
    localparam logic [2:0] F3_000    = 3'b000;
    localparam logic [2:0] F3_001    = 3'b001;
    localparam logic [2:0] F3_010    = 3'b010;

    function automatic insn_t decode(input logic [31:0] chunk);
        logic [9:0] key;
        key    = {chunk[31:25], chunk[14:12]};
        decode = ILLEGAL;
        case (key)
            {F7_ARITH,  F3_000}: decode = ADD;
            {F7_ARITH,  F3_010}: decode = SUB;
            {F7_SHIFT,  F3_000}: decode = SHIFT_LEFT;
            {F7_SHIFT,  F3_010}: decode = SHIFT_RIGHT;
            {F7_MULDIV, F3_000}: decode = MUL_LOW;
            {F7_MULDIV, F3_001}: decode = MUL_HIGH;
`ifdef ALU_MC_DIV_EN
            {F7_MULDIV, F3_010}: decode = DIV;
`endif
            default:             decode = ILLEGAL;
        endcase
    endfunction

endpackage

// File: rtl/alu_mc_div.sv
// alu_mc_div: iterative restoring unsigned divider, one quotient bit per cycle.
// The first step runs on the start edge, so done rises DATA_WIDTH cycles after start.
module alu_mc_div
    import alu_mc_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic [DATA_WIDTH-1:0] dividend,
    input  logic [DATA_WIDTH-1:0] divisor,
    output logic                  busy,
    output logic                  done,
    output logic [DATA_WIDTH-1:0] quotient
);
    localparam int CNT_W = $clog2(DATA_WIDTH + 1);

    logic [DATA_WIDTH-1:0] rem_q, rem_d, quo_q, quo_d, dvs_q, dvs_d;
    logic [DATA_WIDTH-1:0] src_rem, src_quo, src_dvs;
    logic [DATA_WIDTH:0]   trial;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  busy_q, busy_d;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rem_q  <= '0;
            quo_q  <= '0;
            dvs_q  <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
        end else begin
            rem_q  <= rem_d;
            quo_q  <= quo_d;
            dvs_q  <= dvs_d;
            cnt_q  <= cnt_d;
            busy_q <= busy_d;
        end
    end

    always_comb begin
        src_rem = start ? '0 : rem_q;
        src_quo = start ? dividend : quo_q;
        src_dvs = start ? divisor : dvs_q;
        // Borrow out of the trial subtraction means the divisor did not fit.
        trial   = {src_rem, src_quo[DATA_WIDTH-1]} - {1'b0, src_dvs};
        rem_d   = rem_q;
        quo_d   = quo_q;
        dvs_d   = dvs_q;
        cnt_d   = cnt_q;
        busy_d  = busy_q;
        if (start || (busy_q && cnt_q != '0)) begin
            if (trial[DATA_WIDTH]) begin
                rem_d = {src_rem[DATA_WIDTH-2:0], src_quo[DATA_WIDTH-1]};
                quo_d = {src_quo[DATA_WIDTH-2:0], 1'b0};
            end else begin
                rem_d = trial[DATA_WIDTH-1:0];
                quo_d = {src_quo[DATA_WIDTH-2:0], 1'b1};
            end
            dvs_d  = src_dvs;
            cnt_d  = (start ? CNT_W'(DATA_WIDTH) : cnt_q) - CNT_W'(1);
            busy_d = 1'b1;
        end else if (busy_q) begin
            busy_d = 1'b0;
        end
    end

    assign busy     = busy_q;
    assign done     = busy_q && (cnt_q == '0);
    assign quotient = quo_q;

endmodule

// File: rtl/alu_mc.sv
// alu_mc: multi-cycle ALU with valid/ready handshakes on input and output.
// Define ALU_MC_DIV_EN to build the iterative divider; otherwise DIV decodes as ILLEGAL.
module alu_mc
    import alu_mc_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int MUL_LAT    = 2
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [31:0]           chunk,
    input  logic [DATA_WIDTH-1:0] arg1,
    input  logic [DATA_WIDTH-1:0] arg2,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] res,
    output logic                  err
);
    localparam int CNT_W = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;

    state_t                  state_q, state_d;
    insn_t                   op_q, op_d, new_op, mul_op;
    logic [DATA_WIDTH-1:0]   arg1_q, arg1_d, arg2_q, arg2_d, res_q, res_d;
    logic [DATA_WIDTH-1:0]   mul_a, mul_b, mul_result;
    logic [2*DATA_WIDTH-1:0] product;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic                    err_q, err_d, init_q, accept;

`ifdef ALU_MC_DIV_EN
    logic                  div_start, div_busy, div_done;
    logic [DATA_WIDTH-1:0] div_quotient;

    alu_mc_div #(.DATA_WIDTH(DATA_WIDTH)) u_div (
        .clk      (clk),
        .reset_n  (reset_n),
        .start    (div_start),
        .dividend (arg1),
        .divisor  (arg2),
        .busy     (div_busy),
        .done     (div_done),
        .quotient (div_quotient)
    );
`endif

    function automatic logic [DATA_WIDTH-1:0] alu_quick(input insn_t op,
                                                       input logic [DATA_WIDTH-1:0] a,
                                                       input logic [DATA_WIDTH-1:0] b);
        logic big_shift;
        big_shift = (b >= DATA_WIDTH'(DATA_WIDTH));
        case (op)
            ADD:         alu_quick = a + b;
            SUB:         alu_quick = a - b;
            SHIFT_LEFT:  alu_quick = big_shift ? '0 : a << b;
            SHIFT_RIGHT: alu_quick = big_shift ? '0 : a >> b;
            default:     alu_quick = '0;
        endcase
    endfunction

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            op_q    <= ADD;
            arg1_q  <= '0;
            arg2_q  <= '0;
            cnt_q   <= '0;
            res_q   <= '0;
            err_q   <= 1'b0;
            init_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            arg1_q  <= arg1_d;
            arg2_q  <= arg2_d;
            cnt_q   <= cnt_d;
            res_q   <= res_d;
            err_q   <= err_d;
            init_q  <= 1'b1;
        end
    end

    // One multiplier serves both the MUL_LAT=1 accept path and the delayed path.
    always_comb begin
        mul_a      = (state_q == ST_MUL) ? arg1_q : arg1;
        mul_b      = (state_q == ST_MUL) ? arg2_q : arg2;
        mul_op     = (state_q == ST_MUL) ? op_q : new_op;
        product    = {{DATA_WIDTH{1'b0}}, mul_a} * {{DATA_WIDTH{1'b0}}, mul_b};
        mul_result = (mul_op == MUL_HIGH) ? product[2*DATA_WIDTH-1:DATA_WIDTH]
                                          : product[DATA_WIDTH-1:0];
    end

    // NOTE: every _d defaults to its _q first, so no path through this block infers a latch.
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        arg1_d  = arg1_q;
        arg2_d  = arg2_q;
        cnt_d   = cnt_q;
        res_d   = res_q;
        err_d   = err_q;
        new_op  = decode(chunk);
        accept  = in_valid && in_ready;
`ifdef ALU_MC_DIV_EN
        div_start = 1'b0;
`endif
        case (state_q)
            ST_IDLE: ;
            ST_MUL: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = ST_DONE;
                    res_d   = mul_result;
                end
            end
`ifdef ALU_MC_DIV_EN
            ST_DIV: begin
                if (div_done) begin
                    state_d = ST_DONE;
                    res_d   = div_quotient;
                end else if (!div_busy) begin
                    state_d = ST_IDLE;
                end
            end
`endif
            ST_DONE: if (out_ready) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        // A new accept overrides the DONE->IDLE return, giving 1 op/cycle throughput.
        if (accept) begin
            op_d    = new_op;
            arg1_d  = arg1;
            arg2_d  = arg2;
            state_d = ST_DONE;
            res_d   = alu_quick(new_op, arg1, arg2);
            err_d   = 1'b0;
            case (new_op)
                MUL_LOW, MUL_HIGH: begin
                    if (MUL_LAT > 1) begin
                        state_d = ST_MUL;
                        cnt_d   = CNT_W'(MUL_LAT - 1);
                    end else begin
                        res_d = mul_result;
                    end
                end
`ifdef ALU_MC_DIV_EN
                DIV: begin
                    if (arg2 == '0) begin
                        res_d = '1;
                        err_d = 1'b1;
                    end else begin
                        state_d   = ST_DIV;
                        div_start = 1'b1;
                    end
                end
`endif
                ILLEGAL: begin
                    res_d = '0;
                    err_d = 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        in_ready  = init_q && ((state_q == ST_IDLE) || ((state_q == ST_DONE) && out_ready));
        out_valid = (state_q == ST_DONE);
        res       = res_q;
        err       = err_q;
    end

endmodule
